// File: rtl/response_misr.sv
// response_misr: multiple-input signature register with an IDLE/RUN/DONE
// controller. Compacts CYCLES valid response vectors into a WIDTH-bit
// signature, then holds it until the next start.
module response_misr #(
    parameter int               WIDTH  = 7,
    parameter logic [WIDTH-1:0] POLY   = 7'h60,
    parameter logic [WIDTH-1:0] SEED   = 7'h00,
    parameter int               CYCLES = 16,
    parameter int               CNT_W  = $clog2(CYCLES+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sig,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CYCLES - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, done_q;
    logic             fb;
    logic [WIDTH-1:0] sig_step;

    // Fibonacci feedback: parity of the tapped bits enters at bit 0,
    // then the whole response vector is folded in.
    always_comb begin
        fb       = ^(sig_q & POLY);
        sig_step = {sig_q[WIDTH-2:0], fb} ^ resp;
    end

    // Next-state, signature and counter decode; start only acts outside RUN,
    // and vectors are only compacted while in RUN.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    sig_d   = SEED;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (resp_valid) begin
                    sig_d = sig_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX)
                        state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                sig_d   = SEED;
                cnt_d   = '0;
            end
        endcase
    end

    // State, signature and counter registers; status flags are registered
    // from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sig   = sig_q;
    assign count = cnt_q;

endmodule

// File: tb/tb_response_misr.sv
// tb_response_misr: directed checks of response_misr with hand-computed
// signatures. Instance a uses CYCLES=3, instance b the default config.
module tb_response_misr;

    logic       clk = 1'b0;
    logic       rst, start, resp_valid;
    logic [6:0] resp;
    logic       busy, done;
    logic [6:0] sig;
    logic [1:0] count;

    logic       rst_b, start_b, resp_valid_b;
    logic [6:0] resp_b;
    logic       busy_b, done_b;
    logic [6:0] sig_b;
    logic [4:0] count_b;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    response_misr #(.CYCLES(3)) u_a (
        .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid),
        .resp(resp), .busy(busy), .done(done), .sig(sig), .count(count)
    );

    response_misr u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .resp_valid(resp_valid_b),
        .resp(resp_b), .busy(busy_b), .done(done_b), .sig(sig_b), .count(count_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive instance a for one clock, then settle 1 time unit past the edge
    task automatic step(input logic s, input logic v, input logic [6:0] r);
        start = s; resp_valid = v; resp = r;
        @(posedge clk); #1;
    endtask

    task automatic chk_a(input string tag, input logic [6:0] es, input logic [1:0] ec,
                         input logic eb, input logic ed);
        chk({tag, ".sig"},   32'(sig),   32'(es));
        chk({tag, ".count"}, 32'(count), 32'(ec));
        chk({tag, ".busy"},  32'(busy),  32'(eb));
        chk({tag, ".done"},  32'(done),  32'(ed));
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; resp_valid = 1'b1; resp = 7'h7F;
        rst_b = 1'b1; start_b = 1'b0; resp_valid_b = 1'b0; resp_b = 7'h00;

        // reset dominates start/valid
        step(1, 1, 7'h7F); chk_a("rst0", 7'h00, 0, 0, 0);
        step(1, 1, 7'h7F); chk_a("rst1", 7'h00, 0, 0, 0);
        rst = 1'b0; rst_b = 1'b0;
        step(0, 0, 7'h00); chk_a("idle", 7'h00, 0, 0, 0);

        // short run: 01, 40, 00 -> 01, 42, 05
        step(1, 0, 7'h00); chk_a("sr.start", 7'h00, 0, 1, 0);
        step(0, 1, 7'h01); chk_a("sr.v1", 7'h01, 1, 1, 0);
        step(0, 1, 7'h40); chk_a("sr.v2", 7'h42, 2, 1, 0);
        step(0, 1, 7'h00); chk_a("sr.v3", 7'h05, 3, 0, 1);
        step(0, 0, 7'h00); chk_a("sr.hold", 7'h05, 3, 0, 1);

        // valid gaps carrying 7F; restart from DONE
        step(1, 0, 7'h7F); chk_a("gap.start", 7'h00, 0, 1, 0);
        step(0, 0, 7'h7F); chk_a("gap.g0", 7'h00, 0, 1, 0);
        step(0, 1, 7'h01); chk_a("gap.v1", 7'h01, 1, 1, 0);
        step(0, 0, 7'h7F); chk_a("gap.g1", 7'h01, 1, 1, 0);
        step(0, 1, 7'h40); chk_a("gap.v2", 7'h42, 2, 1, 0);
        step(0, 0, 7'h7F);
        step(0, 0, 7'h7F); chk_a("gap.g2", 7'h42, 2, 1, 0);
        step(0, 1, 7'h00); chk_a("gap.v3", 7'h05, 3, 0, 1);

        // ignored inputs: valid in start cycle, start mid-run, valid in DONE
        step(1, 1, 7'h7F); chk_a("ign.start", 7'h00, 0, 1, 0);
        step(0, 1, 7'h01); chk_a("ign.v1", 7'h01, 1, 1, 0);
        step(1, 1, 7'h40); chk_a("ign.v2", 7'h42, 2, 1, 0);
        step(0, 1, 7'h00); chk_a("ign.v3", 7'h05, 3, 0, 1);
        step(0, 1, 7'h7F); chk_a("ign.done", 7'h05, 3, 0, 1);

        // reset mid-run after two vectors
        step(1, 0, 7'h00);
        step(0, 1, 7'h01);
        step(0, 1, 7'h40); chk_a("mr.pre", 7'h42, 2, 1, 0);
        rst = 1'b1;
        step(0, 1, 7'h00); chk_a("mr.rst", 7'h00, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 7'h00); chk_a("mr.idle", 7'h00, 0, 0, 0);
        step(1, 0, 7'h00);
        step(0, 1, 7'h01);
        step(0, 1, 7'h40);
        step(0, 1, 7'h00); chk_a("mr.rerun", 7'h05, 3, 0, 1);

        // default config: 16 all-zero vectors, then restart from DONE
        start_b = 1'b1; @(posedge clk); #1;
        chk("b.start.busy", 32'(busy_b), 32'd1);
        start_b = 1'b0; resp_valid_b = 1'b1; resp_b = 7'h00;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
        end
        chk("b.v15.done", 32'(done_b), 32'd0);
        chk("b.v15.count", 32'(count_b), 32'd15);
        @(posedge clk); #1;
        chk("b.v16.done", 32'(done_b), 32'd1);
        chk("b.v16.busy", 32'(busy_b), 32'd0);
        chk("b.v16.sig", 32'(sig_b), 32'h00);
        chk("b.v16.count", 32'(count_b), 32'd16);
        resp_valid_b = 1'b0; start_b = 1'b1;
        @(posedge clk); #1;
        chk("b.rs.done", 32'(done_b), 32'd0);
        chk("b.rs.busy", 32'(busy_b), 32'd1);
        chk("b.rs.sig", 32'(sig_b), 32'h00);
        chk("b.rs.count", 32'(count_b), 32'd0);
        start_b = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
